// File: rtl/packet_source_arbiter_pkg.sv
// Shared types for the packet source arbiter: FSM state encoding and the
// width of the abort counter.
package packet_source_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    localparam int ABORT_CNT_W = 8;

endpackage

// File: rtl/packet_source_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request found by
// scanning last+1, last+2, ... with wrap modulo COUNT.
module rr_pick
    import packet_source_arbiter_pkg::*;
#(
    parameter int COUNT = 3,
    localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic [COUNT-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = last;
        for (int i = 0; i < COUNT; i++) begin
            cand = (cand == IW'(COUNT - 1)) ? '0 : cand + IW'(1);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/packet_source_arbiter.sv
// Packet-atomic round-robin arbiter feeding one splitter input from COUNT
// pop-style sources. Define PACKET_SOURCE_ARBITER_TIMEOUT_EN to enable the stall abort.
module packet_source_arbiter
    import packet_source_arbiter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT   = 3,
    parameter int TIMEOUT = 255,
    localparam int GW = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COUNT-1:0]       src_nempty,
    input  logic [COUNT*WIDTH-1:0] src_data,
    input  logic [COUNT-1:0]       src_end,
    output logic [COUNT-1:0]       src_pop,
    input  logic                   out_full,
    output logic                   out_shift,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_end,
    output logic                   busy,
    output logic [GW-1:0]          grant,
    output logic [ABORT_CNT_W-1:0] abort_count
);

    state_e           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_q, last_d;
    logic             pick_valid;
    logic [GW-1:0]    pick_idx;
    logic [WIDTH-1:0] words [COUNT];

`ifdef PACKET_SOURCE_ARBITER_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0]          stall_q, stall_d;
    logic [ABORT_CNT_W-1:0] abort_q, abort_d;
`endif

    rr_pick #(.COUNT(COUNT)) u_pick (
        .req   (src_nempty),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int k = 0; k < COUNT; k++) begin
            words[k] = src_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        out_shift = 1'b0;
        src_pop   = '0;
        out_data  = '0;
        out_end   = 1'b0;
`ifdef PACKET_SOURCE_ARBITER_TIMEOUT_EN
        stall_d   = stall_q;
        abort_d   = abort_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ST_BUSY;
`ifdef PACKET_SOURCE_ARBITER_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            ST_BUSY: begin
                out_data         = words[grant_q];
                out_end          = src_end[grant_q];
                out_shift        = src_nempty[grant_q] && !out_full;
                src_pop[grant_q] = out_shift;
                if (out_shift && out_end) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
`ifdef PACKET_SOURCE_ARBITER_TIMEOUT_EN
                // Only an empty granted source counts as a stall, not backpressure.
                if (out_shift) begin
                    stall_d = '0;
                end else if (!src_nempty[grant_q]) begin
                    stall_d = stall_q + 1'b1;
                    if (stall_d == SW'(TIMEOUT)) begin
                        state_d = ST_ABORT;
                    end
                end
`endif
            end
`ifdef PACKET_SOURCE_ARBITER_TIMEOUT_EN
            ST_ABORT: begin
                // Terminate the downstream packet with a zero end word.
                out_end   = 1'b1;
                out_shift = !out_full;
                if (out_shift) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                    stall_d = '0;
                    if (abort_q != '1) begin
                        abort_d = abort_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(COUNT - 1);
`ifdef PACKET_SOURCE_ARBITER_TIMEOUT_EN
            stall_q <= '0;
            abort_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef PACKET_SOURCE_ARBITER_TIMEOUT_EN
            stall_q <= stall_d;
            abort_q <= abort_d;
`endif
        end
    end

    assign busy  = (state_q == ST_BUSY) || (state_q == ST_ABORT);
    assign grant = grant_q;

`ifdef PACKET_SOURCE_ARBITER_TIMEOUT_EN
    assign abort_count = abort_q;
`else
    assign abort_count = '0;
`endif

endmodule

// File: tb/tb_packet_source_arbiter.sv
// Directed table-driven bench for packet_source_arbiter (COUNT=3, WIDTH=8),
// plus hand sequences for mid-packet reset and the optional stall abort.
module tb_packet_source_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  src_nempty;
    logic [23:0] src_data;
    logic [2:0]  src_end;
    logic [2:0]  src_pop;
    logic        out_full;
    logic        out_shift;
    logic [7:0]  out_data;
    logic        out_end;
    logic        busy;
    logic [1:0]  grant;
    logic [7:0]  abort_count;

    int n_vec = 0;
    int n_bad = 0;

    packet_source_arbiter #(.WIDTH(8), .COUNT(3), .TIMEOUT(255)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_nempty  (src_nempty),
        .src_data    (src_data),
        .src_end     (src_end),
        .src_pop     (src_pop),
        .out_full    (out_full),
        .out_shift   (out_shift),
        .out_data    (out_data),
        .out_end     (out_end),
        .busy        (busy),
        .grant       (grant),
        .abort_count (abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic [2:0]  ne;
        logic [23:0] dat;
        logic [2:0]  en;
        logic        fl;
        logic [2:0]  pop;
        logic        sh;
        logic [7:0]  od;
        logic        oe;
        logic        bz;
        logic [1:0]  g;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic rn, input logic [2:0] ne, input logic [23:0] dat,
                                input logic [2:0] en, input logic fl, input logic [2:0] pop,
                                input logic sh, input logic [7:0] od, input logic oe,
                                input logic bz, input logic [1:0] g);
        vec_t v;
        v.rn = rn; v.ne = ne; v.dat = dat; v.en = en; v.fl = fl;
        v.pop = pop; v.sh = sh; v.od = od; v.oe = oe; v.bz = bz; v.g = g;
        vt.push_back(v);
    endfunction

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic drive(input logic rn, input logic [2:0] ne, input logic [23:0] dat,
                         input logic [2:0] en, input logic fl);
        @(negedge clk);
        rst_n = rn; src_nempty = ne; src_data = dat; src_end = en; out_full = fl;
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] pop, input logic sh,
                         input logic [7:0] od, input logic oe, input logic bz,
                         input logic [1:0] g);
        n_vec++;
        if ({src_pop, out_shift, out_data, out_end, busy, grant} !== {pop, sh, od, oe, bz, g}) begin
            n_bad++;
            $display("FAIL %s: got pop=%b shift=%b data=%h end=%b busy=%b grant=%0d, want pop=%b shift=%b data=%h end=%b busy=%b grant=%0d",
                     name, src_pop, out_shift, out_data, out_end, busy, grant, pop, sh, od, oe, bz, g);
        end
    endtask

    task automatic check_ac(input string name, input logic [7:0] exp);
        n_vec++;
        if (abort_count !== exp) begin
            n_bad++;
            $display("FAIL %s: abort_count=%0d, want %0d", name, abort_count, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; src_nempty = '0; src_data = '0; src_end = '0; out_full = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state, then source 1 sends 11,12,13(end)
        add(1, 3'b000, 24'h000000, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0, 2'd0);
        add(1, 3'b010, 24'h001100, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0, 2'd0);
        add(1, 3'b010, 24'h001100, 3'b000, 0, 3'b010, 1, 8'h11, 0, 1, 2'd1);
        add(1, 3'b010, 24'h001200, 3'b000, 0, 3'b010, 1, 8'h12, 0, 1, 2'd1);
        add(1, 3'b010, 24'h001300, 3'b010, 0, 3'b010, 1, 8'h13, 1, 1, 2'd1);
        add(1, 3'b000, 24'h000000, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0, 2'd1);
        // Reset back to last=2, then all three sources with 2-word packets
        add(0, 3'b000, 24'h000000, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0, 2'd1);
        add(1, 3'b111, 24'hA2A1A0, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0, 2'd0);
        add(1, 3'b111, 24'hA2A1A0, 3'b000, 0, 3'b001, 1, 8'hA0, 0, 1, 2'd0);
        add(1, 3'b111, 24'hA2A1B0, 3'b001, 0, 3'b001, 1, 8'hB0, 1, 1, 2'd0);
        add(1, 3'b111, 24'hA2A1A0, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0, 2'd0);
        add(1, 3'b111, 24'hA2A1A0, 3'b000, 0, 3'b010, 1, 8'hA1, 0, 1, 2'd1);
        add(1, 3'b111, 24'hA2B1A0, 3'b010, 0, 3'b010, 1, 8'hB1, 1, 1, 2'd1);
        add(1, 3'b111, 24'hA2A1A0, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0, 2'd1);
        add(1, 3'b111, 24'hA2A1A0, 3'b000, 0, 3'b100, 1, 8'hA2, 0, 1, 2'd2);
        add(1, 3'b111, 24'hB2A1A0, 3'b100, 0, 3'b100, 1, 8'hB2, 1, 1, 2'd2);
        add(1, 3'b111, 24'hA2A1A0, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0, 2'd2);
        add(1, 3'b111, 24'hA2A1A0, 3'b000, 0, 3'b001, 1, 8'hA0, 0, 1, 2'd0);
        add(1, 3'b111, 24'hA2A1B0, 3'b001, 0, 3'b001, 1, 8'hB0, 1, 1, 2'd0);
        // Source 0 alone with out_full toggling, then a 1-word re-grant
        add(1, 3'b001, 24'h000021, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0, 2'd0);
        add(1, 3'b001, 24'h000021, 3'b000, 1, 3'b000, 0, 8'h21, 0, 1, 2'd0);
        add(1, 3'b001, 24'h000021, 3'b000, 0, 3'b001, 1, 8'h21, 0, 1, 2'd0);
        add(1, 3'b001, 24'h000022, 3'b000, 1, 3'b000, 0, 8'h22, 0, 1, 2'd0);
        add(1, 3'b001, 24'h000022, 3'b000, 0, 3'b001, 1, 8'h22, 0, 1, 2'd0);
        add(1, 3'b001, 24'h000023, 3'b001, 1, 3'b000, 0, 8'h23, 1, 1, 2'd0);
        add(1, 3'b001, 24'h000023, 3'b001, 0, 3'b001, 1, 8'h23, 1, 1, 2'd0);
        add(1, 3'b001, 24'h000031, 3'b001, 0, 3'b000, 0, 8'h00, 0, 0, 2'd0);
        add(1, 3'b001, 24'h000031, 3'b001, 0, 3'b001, 1, 8'h31, 1, 1, 2'd0);
        // Source 2 granted, empty for 10 cycles while source 0 waits
        add(1, 3'b101, 24'h410051, 3'b000, 0, 3'b000, 0, 8'h00, 0, 0, 2'd0);
        add(1, 3'b101, 24'h410051, 3'b000, 0, 3'b100, 1, 8'h41, 0, 1, 2'd2);
        for (int i = 0; i < 10; i++)
            add(1, 3'b001, 24'h420051, 3'b100, 0, 3'b000, 0, 8'h42, 1, 1, 2'd2);
        add(1, 3'b101, 24'h420051, 3'b100, 0, 3'b100, 1, 8'h42, 1, 1, 2'd2);
        add(1, 3'b001, 24'h000051, 3'b001, 0, 3'b000, 0, 8'h00, 0, 0, 2'd2);
        add(1, 3'b001, 24'h000051, 3'b001, 0, 3'b001, 1, 8'h51, 1, 1, 2'd0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rn, vt[i].ne, vt[i].dat, vt[i].en, vt[i].fl);
            check($sformatf("vec%0d", i), vt[i].pop, vt[i].sh, vt[i].od, vt[i].oe, vt[i].bz, vt[i].g);
        end
        check_ac("abort_count_idle", 8'd0);

        // Reset asserted for one cycle in the middle of a source 1 packet
        drive(1, 3'b010, 24'h006100, 3'b000, 0);
        check("rst_pre_idle", 3'b000, 0, 8'h00, 0, 0, 2'd0);
        drive(1, 3'b010, 24'h006100, 3'b000, 0);
        check("rst_pre_busy", 3'b010, 1, 8'h61, 0, 1, 2'd1);
        drive(0, 3'b010, 24'h006200, 3'b000, 0);
        drive(1, 3'b000, 24'h000000, 3'b000, 0);
        check("rst_after", 3'b000, 0, 8'h00, 0, 0, 2'd0);
        check_ac("rst_abort_count", 8'd0);
        drive(1, 3'b011, 24'h006271, 3'b001, 0);
        check("rst_rearb_idle", 3'b000, 0, 8'h00, 0, 0, 2'd0);
        drive(1, 3'b011, 24'h006271, 3'b001, 0);
        check("rst_rearb_src0", 3'b001, 1, 8'h71, 1, 1, 2'd0);

`ifdef PACKET_SOURCE_ARBITER_TIMEOUT_EN
        // Source 1 stalls for TIMEOUT cycles after its first word
        drive(1, 3'b110, 24'hA19100, 3'b000, 0);
        check("to_idle", 3'b000, 0, 8'h00, 0, 0, 2'd0);
        drive(1, 3'b110, 24'hA19100, 3'b000, 0);
        check("to_first", 3'b010, 1, 8'h91, 0, 1, 2'd1);
        for (int i = 0; i < 255; i++) begin
            drive(1, 3'b100, 24'hA19200, 3'b000, 0);
            if (i == 0) check("to_stall", 3'b000, 0, 8'h92, 0, 1, 2'd1);
        end
        drive(1, 3'b100, 24'hA19200, 3'b000, 0);
        check("to_abort_word", 3'b000, 1, 8'h00, 1, 1, 2'd1);
        drive(1, 3'b100, 24'hA19200, 3'b100, 0);
        check("to_after_idle", 3'b000, 0, 8'h00, 0, 0, 2'd1);
        check_ac("to_abort_count", 8'd1);
        drive(1, 3'b100, 24'hA19200, 3'b100, 0);
        check("to_next_grant", 3'b100, 1, 8'hA1, 1, 1, 2'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
